// File: rtl/qam64_symbol_mapper_if.sv
// FIFO read port plus symbol valid/ready bus for the 64-QAM symbol mapper.
// master = mapper side, slave = FIFO/downstream side.
interface qam64_symbol_mapper_if #(
  parameter int IQ_WIDTH = 4
);
  logic                       empty;
  logic [7:0]                 data_out;
  logic                       read_enable;
  logic                       sym_ready;
  logic                       sym_valid;
  logic signed [IQ_WIDTH-1:0] sym_i;
  logic signed [IQ_WIDTH-1:0] sym_q;

  modport master (
    input  empty, data_out, sym_ready,
    output read_enable, sym_valid, sym_i, sym_q
  );

  modport slave (
    output empty, data_out, sym_ready,
    input  read_enable, sym_valid, sym_i, sym_q
  );
endinterface

// File: rtl/qam64_symbol_mapper.sv
// Regroups FIFO bytes into 6-bit symbols (MSB first) and maps them to signed I/Q levels.
// Define QAM_GRAY_EN for the Gray-coded level map; otherwise level = 2*b - 7.
module qam64_symbol_mapper #(
  parameter int IQ_WIDTH = 4
) (
  input  logic                   read_clk,
  input  logic                   read_reset_n,
  qam64_symbol_mapper_if.master  sym_bus
);

  logic [15:0]                r_bitbuf;
  logic [4:0]                 r_count;
  logic                       r_fetch_pending;
  logic                       r_sym_valid;
  logic signed [IQ_WIDTH-1:0] r_sym_i;
  logic signed [IQ_WIDTH-1:0] r_sym_q;

  logic        w_load;
  logic [4:0]  w_cnt_sh;
  logic [15:0] w_buf_sh;
  logic [5:0]  w_proj;
  logic [15:0] w_byte_al;
  logic [15:0] w_bitbuf_nxt;

  function automatic logic signed [IQ_WIDTH-1:0] map3(input logic [2:0] b);
    logic [2:0] idx;
    logic [3:0] lvl;
`ifdef QAM_GRAY_EN
    idx[2] = b[2];
    idx[1] = b[2] ^ b[1];
    idx[0] = idx[1] ^ b[0];
`else
    idx = b;
`endif
    // 2*idx - 7 in 4-bit two's complement is {~idx[2], idx[1:0], 1}
    lvl = {~idx[2], idx[1:0], 1'b1};
    return {{(IQ_WIDTH-3){lvl[3]}}, lvl[2:0]};
  endfunction

  assign w_load   = (r_count >= 5'd6) && (!r_sym_valid || sym_bus.sym_ready);
  assign w_cnt_sh = r_count - (w_load ? 5'd6 : 5'd0);
  assign w_buf_sh = w_load ? {r_bitbuf[9:0], 6'b0} : r_bitbuf;
  assign w_proj   = {1'b0, w_cnt_sh} + (r_fetch_pending ? 6'd8 : 6'd0);

  // Projected occupancy <= 8 guarantees room for the byte arriving next cycle.
  assign sym_bus.read_enable = !sym_bus.empty && read_reset_n && (w_proj <= 6'd8);

  assign w_byte_al    = {sym_bus.data_out, 8'h00} >> w_cnt_sh;
  assign w_bitbuf_nxt = r_fetch_pending ? (w_buf_sh | w_byte_al) : w_buf_sh;

  always_ff @(posedge read_clk or negedge read_reset_n) begin
    if (!read_reset_n) begin
      r_bitbuf        <= 16'h0000;
      r_count         <= 5'd0;
      r_fetch_pending <= 1'b0;
      r_sym_valid     <= 1'b0;
      r_sym_i         <= '0;
      r_sym_q         <= '0;
    end else begin
      r_bitbuf        <= w_bitbuf_nxt;
      r_count         <= w_proj[4:0];
      r_fetch_pending <= sym_bus.read_enable;
      if (w_load) begin
        r_sym_valid <= 1'b1;
        r_sym_i     <= map3(r_bitbuf[15:13]);
        r_sym_q     <= map3(r_bitbuf[12:10]);
      end else if (sym_bus.sym_ready) begin
        r_sym_valid <= 1'b0;
      end
    end
  end

  assign sym_bus.sym_valid = r_sym_valid;
  assign sym_bus.sym_i     = r_sym_i;
  assign sym_bus.sym_q     = r_sym_q;

endmodule
